scan_capture_8seg: RTL and testbench
====================================

# scan_capture_8seg

Recovers hex digits from a multiplexed 8-segment LED drive bus, the inverse of the nibble-to-segment decoding used for the board displays. It samples the digit-select and segment lines, waits for each select/pattern pair to be stable, and maps the segment pattern back to a nibble and dot. Results go into a per-digit register file and are also reported as single-cycle events. The block sits between the display pins (or a snooped display bus) and the host-visible register space, for self-test and display readback.

## Interface
- DIGITS, 4, number of multiplexed digits (width of sel, size of register file; 1..16)
- STABLE, 4, consecutive identical synchronized samples required before commit (2..255)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sel  in  DIGITS  digit select, active-high, one-hot when driving; asynchronous to clk
- leds  in  8  {dot, g,f,e,d,c,b,a}, active-high; asynchronous to clk
- clear  in  1  synchronous; clears every entry's known bit
- valid  out  1  one-cycle pulse: a digit was decoded and stored
- err  out  1  one-cycle pulse: stable pair was unrecognised or sel was multi-hot
- digit_idx  out  clog2(DIGITS), min 1  digit index of the last valid/err event
- tetrade  out  4  decoded nibble of the last valid event
- dot  out  1  dot bit of the last valid event
- rd_idx  in  clog2(DIGITS), min 1  register-file read address
- rd_known  out  1  entry holds a decoded digit
- rd_tetrade  out  4  entry nibble
- rd_dot  out  1  entry dot

## Operation
- sel and leds pass through a 2-flop synchronizer (s1, s2), reset to all zeros.
- Hold register h = {sel, leds} and counter c (width fits STABLE-1).
  - If s2 != h: h <= s2, c <= 0.
  - Else if c < STABLE-1: c <= c+1.
  - c saturates at STABLE-1. A commit fires on the edge where c goes STABLE-2 -> STABLE-1, so exactly one commit occurs per stable episode.
- Commit classification, in priority order:
  - sel == 0: nothing happens (blanking interval).
  - sel multi-hot: err pulses, digit_idx = lowest set bit, no store.
  - leds[6:0] == 0000000: entry[idx] gets known=0, tetrade=0, dot=0. No valid, no err.
  - leds[6:0] matches a code: entry[idx] gets {known=1, tetrade, dot=leds[7]}. valid pulses, and digit_idx, tetrade and dot are updated.
  - Any other pattern: err pulses, digit_idx is updated, entry unchanged.
- Code map (gfedcba to nibble):
  - 0111111=0, 0000110=1, 1011011=2, 1001111=3
  - 1100110=4, 1101101=5, 1111101=6, 0000111=7
  - 1111111=8, 1101111=9, 1110111=A, 1111100=b
  - 0111001=C, 1011110=d, 1111001=E, 1110001=F
- clear zeroes known in all entries. If clear and a storing commit happen on the same edge, the committed entry takes the commit and all other entries are cleared.
- If idx >= DIGITS it cannot arise, because sel is DIGITS wide.
- rd_* are combinational reads of the register file.

## Timing
- Reset values:
  - s1, s2, h, c = 0.
  - valid, err, dot = 0; digit_idx, tetrade = 0.
  - All entries {0,0,0}.
- Because h resets to 0, the idle bus (sel=0) is already held at reset and produces no commit.
- Latency: the pins must be constant so that s1 captures STABLE identical samples starting at edge P. valid/err is then high for exactly the cycle following edge P+STABLE+1.
- Back-to-back episodes are allowed. Minimum spacing between commits is STABLE cycles.
- Any change of sel or leds before the commit edge restarts the count. A change after the commit edge starts a new episode.
- valid and err are never high in the same cycle.
- Asserting rst_n low mid-count aborts the episode. After release, the pattern needs a full STABLE samples again.
- rd_* follow a storing commit or clear from the cycle after the edge.

## Test plan
- Reset: hold rst_n=0 with arbitrary pins, then release with sel=0 -> valid=err=0 indefinitely; rd_known=0 for every rd_idx.
- STABLE=4. Drive sel=0010, leds=1_1011011 for 6 cycles from edge P -> one valid pulse in the cycle after P+5 with digit_idx=1, tetrade=2, dot=1; rd_idx=1 reads known=1, tetrade=2, dot=1.
- Glitch: sel=0001 with 0_0000110 for 3 samples, then 0_1001111 for 5 samples -> no pulse for 1, then one valid with tetrade=3, digit_idx=0.
- Errors:
  - sel=0001, leds=0_1010101 stable -> err pulse, digit_idx=0, entry 0 unchanged.
  - sel=0011 stable -> err pulse, digit_idx=0.
  - sel=0000 -> nothing.
- Sweep all 16 codes across digits 0..3 with dot alternating -> 16 valid pulses with matching tetrade/dot and a correct register file. Then commit blank 0_0000000 on digit 2 -> rd_known(2)=0, no pulse.
- clear on the same edge as a commit of 5 to digit 3 -> entry 3 known=1, tetrade=5; entries 0..2 known=0. Pull rst_n low at c=2 -> no pulse, all outputs at reset values.

Source files
------------

// File: rtl/scan_capture_8seg_if.sv
// Display-bus snoop interface: pin inputs, event outputs and register-file read port.
interface scan_capture_8seg_if #(
  parameter int unsigned DIGITS = 4
) ();
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIGITS-1:0] sel;
  logic [7:0]        leds;
  logic              clear;
  logic              valid;
  logic              err;
  logic [IdxW-1:0]   digit_idx;
  logic [3:0]        tetrade;
  logic              dot;
  logic [IdxW-1:0]   rd_idx;
  logic              rd_known;
  logic [3:0]        rd_tetrade;
  logic              rd_dot;

  modport master (
    output sel, leds, clear, rd_idx,
    input  valid, err, digit_idx, tetrade, dot, rd_known, rd_tetrade, rd_dot
  );

  modport slave (
    input  sel, leds, clear, rd_idx,
    output valid, err, digit_idx, tetrade, dot, rd_known, rd_tetrade, rd_dot
  );
endinterface

// File: rtl/scan_capture_8seg.sv
// Multiplexed 8-segment bus capture: synchronize, debounce each sel/leds pair,
// decode the segment pattern back to a nibble and store it per digit.
module scan_capture_8seg #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned STABLE = 4
) (
  input logic               clk,
  input logic               rst_n,
  scan_capture_8seg_if.slave bus
);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW = $clog2(STABLE);
  localparam int unsigned HW   = DIGITS + 8;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE - 1);
  localparam logic [CntW-1:0] CntPre = CntW'(STABLE - 2);

  logic [HW-1:0]     r_s1, r_s2, r_h;
  logic [CntW-1:0]   r_c;
  logic              r_valid, r_err, r_dot;
  logic [IdxW-1:0]   r_idx;
  logic [3:0]        r_tet;
  logic [DIGITS-1:0] r_known;
  logic [3:0]        r_ent_tet [DIGITS];
  logic [DIGITS-1:0] r_ent_dot;

  logic [DIGITS-1:0] w_sel;
  logic [6:0]        w_seg;
  logic              w_dp;
  logic              w_commit, w_multi, w_blank, w_hit, w_store, w_valid_ev, w_err_ev;
  logic [3:0]        w_nib;
  logic [IdxW-1:0]   w_low_idx;

  assign w_sel    = r_h[HW-1:8];
  assign w_seg    = r_h[6:0];
  assign w_dp     = r_h[7];
  // Fires only on the c: STABLE-2 -> STABLE-1 transition, so once per episode.
  assign w_commit = (r_s2 == r_h) && (r_c == CntPre);
  assign w_multi  = (w_sel & (w_sel - DIGITS'(1))) != '0;
  assign w_blank  = (w_seg == 7'b0000000);

  assign w_store    = w_commit && (w_sel != '0) && !w_multi && (w_blank || w_hit);
  assign w_valid_ev = w_commit && (w_sel != '0) && !w_multi && !w_blank && w_hit;
  assign w_err_ev   = w_commit && (w_sel != '0) && (w_multi || (!w_blank && !w_hit));

  // Lowest set select bit gives the digit index (also used for multi-hot errors).
  always_comb begin
    w_low_idx = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (w_sel[i]) w_low_idx = IdxW'(i);
    end
  end

  // Segment pattern (gfedcba) back to hex nibble.
  always_comb begin
    w_hit = 1'b1;
    w_nib = 4'h0;
    case (w_seg)
      7'b0111111: w_nib = 4'h0;
      7'b0000110: w_nib = 4'h1;
      7'b1011011: w_nib = 4'h2;
      7'b1001111: w_nib = 4'h3;
      7'b1100110: w_nib = 4'h4;
      7'b1101101: w_nib = 4'h5;
      7'b1111101: w_nib = 4'h6;
      7'b0000111: w_nib = 4'h7;
      7'b1111111: w_nib = 4'h8;
      7'b1101111: w_nib = 4'h9;
      7'b1110111: w_nib = 4'hA;
      7'b1111100: w_nib = 4'hB;
      7'b0111001: w_nib = 4'hC;
      7'b1011110: w_nib = 4'hD;
      7'b1111001: w_nib = 4'hE;
      7'b1110001: w_nib = 4'hF;
      default:    w_hit = 1'b0;
    endcase
  end

  // Two-flop synchronizer, hold register and saturating stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_h  <= '0;
      r_c  <= '0;
    end else begin
      r_s1 <= {bus.sel, bus.leds};
      r_s2 <= r_s1;
      if (r_s2 != r_h) begin
        r_h <= r_s2;
        r_c <= '0;
      end else if (r_c < CntMax) begin
        r_c <= r_c + CntW'(1);
      end
    end
  end

  // Event pulses; digit_idx follows valid and err, nibble/dot follow valid only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_tet   <= 4'h0;
      r_dot   <= 1'b0;
    end else begin
      r_valid <= w_valid_ev;
      r_err   <= w_err_ev;
      if (w_valid_ev || w_err_ev) r_idx <= w_low_idx;
      if (w_valid_ev) begin
        r_tet <= w_nib;
        r_dot <= w_dp;
      end
    end
  end

  // Register file; a store on the clear edge wins for its own entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_known   <= '0;
      r_ent_dot <= '0;
      for (int i = 0; i < DIGITS; i++) r_ent_tet[i] <= 4'h0;
    end else begin
      if (bus.clear) r_known <= '0;
      if (w_store) begin
        r_known[w_low_idx]   <= w_hit;
        r_ent_tet[w_low_idx] <= w_hit ? w_nib : 4'h0;
        r_ent_dot[w_low_idx] <= w_hit & w_dp;
      end
    end
  end

  assign bus.valid      = r_valid;
  assign bus.err        = r_err;
  assign bus.digit_idx  = r_idx;
  assign bus.tetrade    = r_tet;
  assign bus.dot        = r_dot;
  assign bus.rd_known   = r_known[bus.rd_idx];
  assign bus.rd_tetrade = r_ent_tet[bus.rd_idx];
  assign bus.rd_dot     = r_ent_dot[bus.rd_idx];
endmodule

// File: tb/tb_scan_capture_8seg.sv
// Scoreboard bench: a sample-history model predicts events and register-file contents.
module tb_scan_capture_8seg;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned STABLE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scan_capture_8seg_if #(.DIGITS(DIGITS)) bus ();
  scan_capture_8seg #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {bit is_err; int idx; int tet; int dot; int due;} ev_t;
  typedef struct {int due; int idx; int known; int tet; int dot;} st_t;
  ev_t exp_q[$];
  st_t st_q[$];

  int m_known[DIGITS];
  int m_tet[DIGITS];
  int m_dot[DIGITS];
  logic [11:0] m_last;
  bit m_have = 1'b0;
  int m_run  = 0;
  int m_vtet = 0;
  int m_vdot = 0;

  logic [6:0] seg_tab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Classify a pattern that has just been seen STABLE times in a row.
  function automatic void model_commit(input logic [11:0] s);
    logic [3:0] sl;
    logic [7:0] l;
    int idx;
    int nib;
    sl  = s[11:8];
    l   = s[7:0];
    idx = 0;
    nib = -1;
    if (sl == 4'b0000) return;
    for (int i = DIGITS - 1; i >= 0; i--) if (sl[i]) idx = i;
    if ($countones(sl) > 1) begin
      exp_q.push_back('{1'b1, idx, m_vtet, m_vdot, cyc + 2});
      return;
    end
    if (l[6:0] == 7'd0) begin
      st_q.push_back('{cyc + 2, idx, 0, 0, 0});
      return;
    end
    for (int i = 0; i < 16; i++) if (seg_tab[i] == l[6:0]) nib = i;
    if (nib < 0) begin
      exp_q.push_back('{1'b1, idx, m_vtet, m_vdot, cyc + 2});
    end else begin
      m_vtet = nib;
      m_vdot = int'(l[7]);
      exp_q.push_back('{1'b0, idx, m_vtet, m_vdot, cyc + 2});
      st_q.push_back('{cyc + 2, idx, 1, nib, int'(l[7])});
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    st_q.delete();
    for (int i = 0; i < DIGITS; i++) begin
      m_known[i] = 0;
      m_tet[i]   = 0;
      m_dot[i]   = 0;
    end
    m_have = 1'b0;
    m_run  = 0;
    m_vtet = 0;
    m_vdot = 0;
  endfunction

  // One clock: drive pins away from the edge, then advance the model at the edge.
  task automatic tick(input logic [3:0] s, input logic [7:0] l, input bit clr);
    @(negedge clk);
    bus.sel   = s;
    bus.leds  = l;
    bus.clear = clr;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (clr) for (int i = 0; i < DIGITS; i++) m_known[i] = 0;
      while (st_q.size() > 0 && st_q[0].due == cyc) begin
        st_t st;
        st = st_q.pop_front();
        m_known[st.idx] = st.known;
        m_tet[st.idx]   = st.tet;
        m_dot[st.idx]   = st.dot;
      end
      if (m_have && ({s, l} == m_last)) m_run++;
      else m_run = 1;
      m_last = {s, l};
      m_have = 1'b1;
      if (m_run == STABLE) model_commit({s, l});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(4'b0000, 8'h00, 1'b0);
  endtask

  task automatic check_rf();
    for (int i = 0; i < DIGITS; i++) begin
      bus.rd_idx = 2'(i);
      #1;
      check($sformatf("rd_known[%0d]", i), int'(bus.rd_known), m_known[i]);
      check($sformatf("rd_tetrade[%0d]", i), int'(bus.rd_tetrade), m_tet[i]);
      check($sformatf("rd_dot[%0d]", i), int'(bus.rd_dot), m_dot[i]);
    end
  endtask

  task automatic check_out_reset();
    check("rst_valid", int'(bus.valid), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_digit_idx", int'(bus.digit_idx), 0);
    check("rst_tetrade", int'(bus.tetrade), 0);
    check("rst_dot", int'(bus.dot), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports an event.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.valid && bus.err) begin
          n_tests++;
          n_fail++;
          $display("FAIL both_pulses: valid and err high together (cycle %0d)", cyc);
        end
        if (bus.valid || bus.err) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: valid=%0b err=%0b idx=%0d, none expected (cycle %0d)",
                     bus.valid, bus.err, bus.digit_idx, cyc);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("ev_is_err", int'(bus.err), int'(e.is_err));
            check("ev_cycle", cyc, e.due);
            check("ev_digit_idx", int'(bus.digit_idx), e.idx);
            check("ev_tetrade", int'(bus.tetrade), e.tet);
            check("ev_dot", int'(bus.dot), e.dot);
          end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL missed_event: no pulse, expected is_err=%0b idx=%0d due %0d (cycle %0d)",
                   exp_q[0].is_err, exp_q[0].idx, exp_q[0].due, cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] s;
    logic [7:0] l;
    int kind;
    int hold;
    int a;
    int b;

    bus.sel    = '0;
    bus.leds   = '0;
    bus.clear  = 1'b0;
    bus.rd_idx = '0;
    model_reset();

    // Reset with arbitrary pins, released onto an idle bus.
    repeat (3) begin
      @(negedge clk);
      bus.sel  = 4'($urandom);
      bus.leds = 8'($urandom);
    end
    @(negedge clk);
    bus.sel  = '0;
    bus.leds = '0;
    rst_n    = 1'b1;
    check_out_reset();
    idle(10);
    check_rf();

    // Digit 1 shows "2." for six samples.
    repeat (6) tick(4'b0010, 8'b1_1011011, 1'b0);
    idle(STABLE + 2);
    check_rf();

    // Glitch: "1" too short to commit, then "3".
    repeat (3) tick(4'b0001, 8'b0_0000110, 1'b0);
    repeat (5) tick(4'b0001, 8'b0_1001111, 1'b0);
    idle(STABLE + 2);

    // Unknown pattern, multi-hot select, blanking.
    repeat (6) tick(4'b0001, 8'b0_1010101, 1'b0);
    repeat (6) tick(4'b0011, 8'b0_0111111, 1'b0);
    repeat (6) tick(4'b0000, 8'b0_1011011, 1'b0);
    idle(STABLE + 2);
    check_rf();

    // All sixteen codes across the digits with alternating dot.
    for (int i = 0; i < 16; i++) begin
      s = 4'(1 << (i % 4));
      l = {1'(i % 2), seg_tab[i]};
      repeat (STABLE + 1) tick(s, l, 1'b0);
    end
    idle(STABLE + 2);
    check_rf();
    repeat (6) tick(4'b0100, 8'h00, 1'b0);
    idle(STABLE + 2);
    check_rf();

    // clear lands on the same edge as the commit of "5" to digit 3.
    for (int j = 0; j < STABLE + 3; j++) begin
      tick(4'b1000, {1'b0, seg_tab[5]}, j == STABLE + 1);
    end
    idle(STABLE + 2);
    check_rf();

    // Randomized episodes, including clears, errors, blanks and short glitches.
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 9));
      hold = int'($urandom_range(1, STABLE + 3));
      a    = int'($urandom_range(0, 3));
      b    = (a + 1 + int'($urandom_range(0, 2))) % 4;
      s    = 4'(1 << a);
      l    = {1'($urandom), seg_tab[$urandom_range(0, 15)]};
      case (kind)
        0:       s = 4'b0000;
        1:       s = 4'((1 << a) | (1 << b));
        2:       l = {1'($urandom), 7'd0};
        3:       l = 8'($urandom);
        default: ;
      endcase
      repeat (hold) tick(s, l, $urandom_range(0, 9) == 0);
    end
    idle(STABLE + 2);
    check_rf();

    // Reset asserted while c=2 on a "9." episode aborts it.
    repeat (5) tick(4'b0100, {1'b1, seg_tab[9]}, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_out_reset();
    check_rf();
    @(negedge clk);
    bus.sel  = '0;
    bus.leds = '0;
    rst_n    = 1'b1;
    idle(STABLE + 4);
    check_out_reset();

    // Pattern after reset needs a full STABLE run again.
    repeat (STABLE + 1) tick(4'b0100, {1'b1, seg_tab[9]}, 1'b0);
    idle(STABLE + 3);
    check_rf();
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
